// File: rtl/fifo_param_pkg.sv
// Shared FIFO defaults and depth derivation (formerly fifo_defs.vh).
package fifo_param_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 12;
   localparam int unsigned DEF_ADDR_WIDTH = 3;

   function automatic int unsigned depth_of(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_param_memoria_dp.sv
// Dual-port storage: synchronous write, synchronous read with a registered output.
module memoria_dp
   import fifo_param_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   // Storage is deliberately not reset; only the output register is.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO control: wrap-bit pointers, status flags, sticky error flags.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic                  write_enable,
   input  logic                  read_enable,
   input  logic [DATA_WIDTH-1:0] FIFO_data_in,
   input  logic [ADDR_WIDTH:0]   umbral_bajo,
   input  logic [ADDR_WIDTH:0]   umbral_alto,
   input  logic                  clr_error,
   output logic [DATA_WIDTH-1:0] FIFO_data_out,
   output logic                  FIFO_valid,
   output logic                  FIFO_empty,
   output logic                  FIFO_full,
   output logic                  FIFO_almost_empty,
   output logic                  FIFO_almost_full,
   output logic [ADDR_WIDTH:0]   FIFO_count,
   output logic                  FIFO_overflow,
   output logic                  FIFO_underflow
);

   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));

   logic [ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr;
   logic                r_valid, r_overflow, r_underflow;
   logic [ADDR_WIDTH:0] w_count;
   logic                w_empty, w_full, w_push, w_pop, w_ovf_set, w_udf_set;

   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (w_count == '0);
   assign w_full  = (w_count == LP_DEPTH);

   // A pop frees a slot in the same edge, so a full FIFO still takes a push then.
   assign w_pop     = Enable & read_enable & ~w_empty;
   assign w_push    = Enable & write_enable & (~w_full | w_pop);
   assign w_ovf_set = Enable & write_enable & w_full & ~w_pop;
   assign w_udf_set = Enable & read_enable & w_empty;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (Enable) begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_valid     <= w_pop;
         r_overflow  <= w_ovf_set | (r_overflow & ~clr_error);
         r_underflow <= w_udf_set | (r_underflow & ~clr_error);
      end
   end

   memoria_dp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (clk),
      .rst_n     (Reset),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
      .i_wr_data (FIFO_data_in),
      .i_rd_en   (w_pop),
      .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rd_data (FIFO_data_out)
   );

   assign FIFO_valid        = r_valid;
   assign FIFO_count        = w_count;
   assign FIFO_empty        = w_empty;
   assign FIFO_full         = w_full;
   assign FIFO_almost_empty = ~w_empty & (w_count <= umbral_bajo);
   assign FIFO_almost_full  = ~w_full & (w_count >= umbral_alto);
   assign FIFO_overflow     = r_overflow;
   assign FIFO_underflow    = r_underflow;

endmodule
